instr_sequencer: RTL

- Fetch/decode/execute controller for the mini 8-bit CPU.
- Fetches 12-bit instructions (opcode[11:8], imm[7:0]) from program ROM over a req/ack handshake.
- Presents the opcode to the instruction decoder and gates register/ALU enables with a one-cycle exec strobe.
- Owns the PC and supports run, single-step, halt/resume and fetch-timeout.

---
 rtl/instr_seq_pkg.sv | 37 +++
 rtl/instr_sequencer_fetch_timer.sv | 38 +++
 rtl/instr_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and opcode constants for the instruction sequencer.
package instr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  // Opcode map of the mini CPU
  localparam logic [3:0] OP_CLR       = 4'h0;
  localparam logic [3:0] OP_LD1       = 4'h1;
  localparam logic [3:0] OP_LD2A      = 4'h2;
  localparam logic [3:0] OP_LD2B      = 4'h3;
  localparam logic [3:0] OP_ALU_FIRST = 4'h4;
  localparam logic [3:0] OP_ALU_LAST  = 4'h9;
  localparam logic [3:0] OP_HALT      = 4'hF;

  // Encoding that makes the decoder drive every enable low
  localparam logic [3:0] OP_NOP = 4'hF;

  // Unassigned opcodes; they execute as NOP and raise the illegal flag
  localparam logic [3:0] OP_ILL_LO = 4'hA;
  localparam logic [3:0] OP_ILL_HI = 4'hE;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
  endfunction

  // Opcodes that are passed through to the decoder
  function automatic logic op_is_exec(input logic [3:0] op);
    return op <= OP_ALU_LAST;
  endfunction

endpackage

// File: rtl/instr_sequencer_fetch_timer.sv
// Counts FETCH cycles spent waiting for rom_ack; flags the last allowed cycle.
module instr_sequencer_fetch_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and saturate at the last cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the TIMEOUT-th waiting cycle
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: owns the PC, fetches 12-bit words from ROM
// over req/ack, presents opcode/imm and strobes exec_en for one cycle.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  input  logic            resume,
  output logic            rom_req,
  output logic [PC_W-1:0] rom_addr,
  input  logic            rom_ack,
  input  logic [11:0]     rom_data,
  output logic [3:0]      opcode,
  output logic [7:0]      imm,
  output logic            exec_en,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            illegal,
  output logic            fetch_err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            rom_req_q, rom_req_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [3:0]      ir_op_q, ir_op_d;
  logic [7:0]      imm_q, imm_d;
  logic            exec_en_q, exec_en_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic            fetch_err_q, fetch_err_d;

  logic tmr_en, tmr_clr, tmr_expired;

  // The timer only runs in FETCH and restarts on every fetch or ack
  assign tmr_en  = (state_q == ST_FETCH);
  assign tmr_clr = !tmr_en || rom_ack;

  instr_sequencer_fetch_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_fetch_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  // Next-state and next-output logic; outputs are set one cycle ahead so the
  // registered values line up with the state they belong to
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rom_req_d   = rom_req_q;
    opcode_d    = opcode_q;
    ir_op_d     = ir_op_q;
    imm_d       = imm_q;
    exec_en_d   = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    fetch_err_d = fetch_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run || step) begin
          state_d   = ST_FETCH;
          rom_req_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (rom_ack) begin
          // Opcode and imm are presented during DECODE so the decoder settles
          ir_op_d   = rom_data[11:8];
          imm_d     = rom_data[7:0];
          opcode_d  = op_is_exec(rom_data[11:8]) ? rom_data[11:8] : OP_NOP;
          rom_req_d = 1'b0;
          state_d   = ST_DECODE;
        end else if (tmr_expired) begin
          rom_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          state_d     = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (ir_op_q == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          if (op_is_illegal(ir_op_q)) begin
            illegal_d = 1'b1;
          end
          exec_en_d = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d     = pc_q + PC_W'(1);
        opcode_d = OP_NOP;
        if (run) begin
          state_d   = ST_FETCH;
          rom_req_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        // resume has priority; step and run are ignored here
        if (resume) begin
          pc_d     = pc_q + PC_W'(1);
          halted_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      rom_req_q   <= 1'b0;
      opcode_q    <= OP_NOP;
      ir_op_q     <= OP_NOP;
      imm_q       <= '0;
      exec_en_q   <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rom_req_q   <= rom_req_d;
      opcode_q    <= opcode_d;
      ir_op_q     <= ir_op_d;
      imm_q       <= imm_d;
      exec_en_q   <= exec_en_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign rom_req   = rom_req_q;
  assign rom_addr  = pc_q;
  assign pc        = pc_q;
  assign opcode    = opcode_q;
  assign imm       = imm_q;
  assign exec_en   = exec_en_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;
  assign fetch_err = fetch_err_q;

endmodule
